// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions used by the register scoreboard.
// Includes the WB commit bus layout (pc, rf_we, dest, result) and the register/counter sizing.
package reg_scoreboard_pkg;

   localparam int REG_W = 5;
   localparam int NREG  = 32;
   localparam int CNT_W = 2;

   localparam int WB_PC_LSB     = 37;
   localparam int WB_DEST_LSB   = 32;
   localparam int WB_RESULT_LSB = 0;

   typedef logic [REG_W-1:0] reg_idx_t;

   // Field order reproduces the commit bus: rf_we at the top, then pc [68:37], dest [36:32], result [31:0].
   typedef struct packed {
      logic           rf_we;
      logic [31:0]    pc;
      reg_idx_t       dest;
      logic [31:0]    result;
   } wb_commit_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/commit/flush handshake and status bundle between decode, WB and the scoreboard.
interface reg_scoreboard_if;
   import reg_scoreboard_pkg::*;

   logic            issue_valid;
   reg_idx_t        issue_src1;
   logic            issue_src1_used;
   reg_idx_t        issue_src2;
   logic            issue_src2_used;
   logic            issue_rf_we;
   reg_idx_t        issue_dest;
   logic            id_stall;
   logic            issue_fire;
   logic            wb_commit_valid;
   logic            wb_commit_we;
   reg_idx_t        wb_commit_dest;
   logic            flush;
   logic [NREG-1:0] busy_mask;
   logic [3:0]      inflight;
   logic            sb_empty;
   logic            err_underflow;

   modport master (
      output issue_valid, issue_src1, issue_src1_used, issue_src2, issue_src2_used,
             issue_rf_we, issue_dest, wb_commit_valid, wb_commit_we, wb_commit_dest, flush,
      input  id_stall, issue_fire, busy_mask, inflight, sb_empty, err_underflow
   );

   modport slave (
      input  issue_valid, issue_src1, issue_src1_used, issue_src2, issue_src2_used,
             issue_rf_we, issue_dest, wb_commit_valid, wb_commit_we, wb_commit_dest, flush,
      output id_stall, issue_fire, busy_mask, inflight, sb_empty, err_underflow
   );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Per-register pending-write counter: up on issue, down on commit, cleared on flush.
module sb_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         underflow
);

   logic dec_ok;

   // A commit against an empty counter is dropped; the issue side can still count up.
   assign underflow = dec && (cnt == '0);
   assign dec_ok    = dec && (cnt != '0);

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc && !dec_ok)
         cnt <= cnt + 1'b1;
      else if (dec_ok && !inc)
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard and issue interlock: counts in-flight writes per register and
// stalls ID on RAW hazards or when a destination counter is full.
module reg_scoreboard #(
   parameter int CNT_W = reg_scoreboard_pkg::CNT_W,
   parameter int NREG  = reg_scoreboard_pkg::NREG
) (
   input  logic             clk,
   input  logic             reset,
   reg_scoreboard_if.slave  sb
);
   import reg_scoreboard_pkg::REG_W;

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [3:0]       INFLIGHT_MAX = 4'd15;

   logic [CNT_W-1:0] cnt [NREG];
   logic [NREG-1:0]  ufl;
   logic [NREG-1:0]  busy;
   logic [3:0]       inflight_q;
   logic             err_q;
   logic             raw1, raw2, waw_full, stall;
   logic             inc, dec, dec_ok, any_ufl;

   // r0 is hardwired: never busy, never counts.
   assign cnt[0] = '0;
   assign ufl[0] = 1'b0;

   assign raw1     = sb.issue_src1_used && (sb.issue_src1 != '0) && (cnt[sb.issue_src1] != '0);
   assign raw2     = sb.issue_src2_used && (sb.issue_src2 != '0) && (cnt[sb.issue_src2] != '0);
   assign waw_full = sb.issue_rf_we && (sb.issue_dest != '0) && (cnt[sb.issue_dest] == CNT_MAX);
   assign stall    = sb.issue_valid && (raw1 || raw2 || waw_full);

   assign sb.id_stall   = stall;
   assign sb.issue_fire = sb.issue_valid && !stall;

   assign inc     = sb.issue_valid && !stall && sb.issue_rf_we && (sb.issue_dest != '0);
   assign dec     = sb.wb_commit_valid && sb.wb_commit_we && (sb.wb_commit_dest != '0);
   assign any_ufl = |ufl;
   assign dec_ok  = dec && !any_ufl;

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      sb_counter #(.W(CNT_W)) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .clr       (sb.flush),
         .inc       (inc && (sb.issue_dest == REG_W'(i))),
         .dec       (dec && (sb.wb_commit_dest == REG_W'(i))),
         .cnt       (cnt[i]),
         .underflow (ufl[i])
      );
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++)
         busy[i] = (cnt[i] != '0);
   end

   // Flush discards same-cycle issue/commit but keeps the sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else if (sb.flush) begin
         inflight_q <= '0;
      end else begin
         if (inc && !dec_ok && (inflight_q != INFLIGHT_MAX))
            inflight_q <= inflight_q + 4'd1;
         else if (dec_ok && !inc && (inflight_q != 4'd0))
            inflight_q <= inflight_q - 4'd1;
         if (any_ufl)
            err_q <= 1'b1;
      end
   end

   assign sb.busy_mask     = busy;
   assign sb.inflight      = inflight_q;
   assign sb.sb_empty      = (inflight_q == 4'd0);
   assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: a behavioural model pushes expected outputs
// to a queue as each cycle is driven, and they are popped against the DUT.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_scoreboard_if bus ();
   reg_scoreboard dut (.clk(clk), .reset(reset), .sb(bus));

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   int          m_cnt[32];
   int          m_infl = 0;
   bit          m_err  = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_infl = 0;
   endtask

   // One clock cycle: inputs applied after negedge, outputs checked before and after the posedge.
   task automatic step(input bit v, input int s1, input bit s1u, input int s2, input bit s2u,
                       input bit we, input int d, input bit cv, input bit cwe, input int cd,
                       input bit fl, input bit rst);
      bit          stall, inc, dec;
      logic [31:0] mask;
      bus.issue_valid     = v;
      bus.issue_src1      = 5'(s1);
      bus.issue_src1_used = s1u;
      bus.issue_src2      = 5'(s2);
      bus.issue_src2_used = s2u;
      bus.issue_rf_we     = we;
      bus.issue_dest      = 5'(d);
      bus.wb_commit_valid = cv;
      bus.wb_commit_we    = cwe;
      bus.wb_commit_dest  = 5'(cd);
      bus.flush           = fl;
      reset               = rst;
      #1;
      stall = v && ((s1u && s1 != 0 && m_cnt[s1] != 0) ||
                    (s2u && s2 != 0 && m_cnt[s2] != 0) ||
                    (we && d != 0 && m_cnt[d] == 3));
      exp_q.push_back(32'(stall));
      exp_q.push_back(32'(v && !stall));
      check_eq("id_stall", 32'(bus.id_stall), exp_q.pop_front());
      check_eq("issue_fire", 32'(bus.issue_fire), exp_q.pop_front());
      @(posedge clk);
      if (rst) begin
         model_clear();
         m_err = 1'b0;
      end else if (fl) begin
         model_clear();
      end else begin
         inc = v && !stall && we && d != 0;
         dec = cv && cwe && cd != 0;
         if (dec && m_cnt[cd] == 0) begin
            m_err = 1'b1;
            dec   = 1'b0;
         end
         if (inc) m_cnt[d]++;
         if (dec) m_cnt[cd]--;
         if (inc && !dec && m_infl < 15) m_infl++;
         else if (dec && !inc && m_infl > 0) m_infl--;
      end
      mask = '0;
      for (int i = 1; i < 32; i++) mask[i] = (m_cnt[i] != 0);
      exp_q.push_back(mask);
      exp_q.push_back(32'(m_infl));
      exp_q.push_back(32'(m_infl == 0));
      exp_q.push_back(32'(m_err));
      #1;
      check_eq("busy_mask", bus.busy_mask, exp_q.pop_front());
      check_eq("inflight", 32'(bus.inflight), exp_q.pop_front());
      check_eq("sb_empty", 32'(bus.sb_empty), exp_q.pop_front());
      check_eq("err_underflow", 32'(bus.err_underflow), exp_q.pop_front());
      @(negedge clk);
   endtask

   initial begin
      int s1, s2, d, cd;
      bit cv;
      model_clear();
      @(negedge clk);
      step(0,0,0,0,0,0,0,0,0,0,0,1);
      step(0,0,0,0,0,0,0,0,0,0,0,1);
      check_eq("rst_busy", bus.busy_mask, 32'h0);
      check_eq("rst_empty", 32'(bus.sb_empty), 32'd1);

      // idle with a used source: no stall
      step(1,3,1,0,0,0,0,0,0,0,0,0);
      check_eq("idle_stall", 32'(bus.id_stall), 32'd0);

      // RAW on r5 cleared the cycle after commit
      step(1,0,0,0,0,1,5,0,0,0,0,0);
      step(1,5,1,0,0,0,0,0,0,0,0,0);
      step(1,5,1,0,0,0,0,1,1,5,0,0);
      check_eq("raw_cleared", 32'(bus.id_stall), 32'd0);
      step(1,5,1,0,0,0,0,0,0,0,0,0);

      // WAW full on r7
      step(1,0,0,0,0,1,7,0,0,0,0,0);
      step(1,0,0,0,0,1,7,0,0,0,0,0);
      step(1,0,0,0,0,1,7,0,0,0,0,0);
      check_eq("waw_full", 32'(bus.id_stall), 32'd1);
      step(1,0,0,0,0,1,7,0,0,0,0,0);
      step(1,0,0,0,0,1,7,1,1,7,0,0);
      check_eq("waw_release", 32'(bus.id_stall), 32'd0);
      step(1,0,0,0,0,1,7,0,0,0,0,0);
      check_eq("waw_inflight", 32'(bus.inflight), 32'd3);
      step(0,0,0,0,0,0,0,0,0,0,1,0);

      // same-register issue and commit
      step(1,0,0,0,0,1,9,0,0,0,0,0);
      step(1,0,0,0,0,1,9,1,1,9,0,0);
      check_eq("same_reg_inflight", 32'(bus.inflight), 32'd1);
      check_eq("same_reg_busy", bus.busy_mask, 32'h200);
      step(0,0,0,0,0,0,0,1,1,9,0,0);

      // r0 never tracked
      step(1,0,1,0,1,1,0,1,1,0,0,0);
      check_eq("r0_stall", 32'(bus.id_stall), 32'd0);
      check_eq("r0_busy", bus.busy_mask, 32'h0);
      check_eq("r0_inflight", 32'(bus.inflight), 32'd0);

      // underflow sticky across flush, cleared by reset
      step(0,0,0,0,0,0,0,1,1,12,0,0);
      check_eq("ufl_set", 32'(bus.err_underflow), 32'd1);
      for (int r = 1; r <= 4; r++) step(1,0,0,0,0,1,r,0,0,0,0,0);
      check_eq("pre_flush_inflight", 32'(bus.inflight), 32'd4);
      step(1,0,0,0,0,1,6,1,1,1,1,0);
      check_eq("flush_inflight", 32'(bus.inflight), 32'd0);
      check_eq("flush_busy", bus.busy_mask, 32'h0);
      check_eq("flush_err_kept", 32'(bus.err_underflow), 32'd1);
      step(0,0,0,0,0,0,0,0,0,0,0,1);
      check_eq("reset_err", 32'(bus.err_underflow), 32'd0);

      // random traffic, biased toward committing registers that are busy
      for (int n = 0; n < 400; n++) begin
         s1 = $urandom_range(0, 7);
         s2 = $urandom_range(0, 7);
         d  = $urandom_range(0, 7);
         cd = $urandom_range(0, 31);
         cv = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) < 8) begin
            for (int k = 0; k < 32; k++)
               if (m_cnt[(cd + k) % 32] != 0) begin
                  cd = (cd + k) % 32;
                  break;
               end
         end
         step($urandom_range(0, 3) != 0, s1, $urandom_range(0, 1) == 1, s2, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) != 0, d, cv, $urandom_range(0, 5) != 0, cd,
              $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
